// File: rtl/vc_test_rr_merge_if.sv
// Handshake bundle for vc_test_rr_merge: p_nreqs val/rdy requesters in,
// one tagged val/rdy channel out.
interface vc_test_rr_merge_if #(
  parameter int p_nreqs  = 2,
  parameter int p_msg_sz = 8,
  parameter int p_idx_sz = 1
);
  logic [p_nreqs-1:0]          in_val;
  logic [p_nreqs-1:0]          in_rdy;
  logic [p_nreqs*p_msg_sz-1:0] in_msg;
  logic                        out_val;
  logic                        out_rdy;
  logic [p_msg_sz-1:0]         out_msg;
  logic [p_idx_sz-1:0]         out_idx;

  // master: the harness side (sources and sink); slave: the merge block
  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_idx
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_idx
  );
endinterface

// File: rtl/vc_test_rr_merge.sv
// Round-robin merge of p_nreqs val/rdy sources into one single-entry
// output register; each message is tagged with its source index.
module vc_test_rr_merge #(
  parameter int p_nreqs  = 2,
  parameter int p_msg_sz = 8,
  parameter int p_idx_sz = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  vc_test_rr_merge_if.slave  bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]          state;
  logic [p_idx_sz-1:0] ptr;
  logic [p_msg_sz-1:0] msg_q;
  logic [p_idx_sz-1:0] idx_q;

  logic                grant_any;
  logic [p_idx_sz-1:0] grant_idx;
  logic [p_msg_sz-1:0] grant_msg;
  logic                can_accept;
  logic                accept;

  // A draining output register can be refilled in the same cycle.
  assign can_accept = (state == S_EMPTY) || bus.out_rdy;

  // Search ptr, ptr+1, ... (mod p_nreqs); the inner loop keeps every
  // vector index a constant after unrolling.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_msg = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      for (int i = 0; i < p_nreqs; i++) begin
        if (!grant_any && (i == (int'(ptr) + k) % p_nreqs) && bus.in_val[i]) begin
          grant_any = 1'b1;
          grant_idx = p_idx_sz'(i);
          grant_msg = bus.in_msg[i*p_msg_sz +: p_msg_sz];
        end
      end
    end
  end

  // reset_n gates ready so nothing appears accepted while reset is held.
  always_comb begin
    bus.in_rdy = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      bus.in_rdy[i] = grant_any && (int'(grant_idx) == i) && can_accept && reset_n;
    end
  end

  assign accept = grant_any && can_accept;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_EMPTY;
      ptr   <= '0;
      msg_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      state <= S_FULL;
      msg_q <= grant_msg;
      idx_q <= grant_idx;
      ptr   <= (int'(grant_idx) == p_nreqs - 1) ? '0 : grant_idx + 1'b1;
    end else if ((state == S_FULL) && bus.out_rdy) begin
      // Drained with no refill: data and tag keep their stale values.
      state <= S_EMPTY;
    end
  end

  assign bus.out_val = (state == S_FULL);
  assign bus.out_msg = msg_q;
  assign bus.out_idx = idx_q;

endmodule

// File: tb/tb_vc_test_rr_merge.sv
// Directed bench for vc_test_rr_merge: a 2-requester and a 4-requester
// instance driven from per-source message queues.
module tb_vc_test_rr_merge;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  vc_test_rr_merge_if #(.p_nreqs(2), .p_msg_sz(8), .p_idx_sz(1)) b2 ();
  vc_test_rr_merge_if #(.p_nreqs(4), .p_msg_sz(8), .p_idx_sz(2)) b4 ();

  vc_test_rr_merge #(.p_nreqs(2), .p_msg_sz(8), .p_idx_sz(1)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b2.slave)
  );

  vc_test_rr_merge #(.p_nreqs(4), .p_msg_sz(8), .p_idx_sz(2)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b4.slave)
  );

  typedef logic [7:0] mq_t[$];
  mq_t q[4];

  int n_vec = 0;
  int n_bad = 0;

  // Values seen just before the active edge of the last cycle
  logic [3:0] rdy_s;
  logic       oval_s;
  logic [7:0] omsg_s;
  logic [1:0] oidx_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) q[i].delete();
    b2.in_val = '0; b2.in_msg = '0; b2.out_rdy = 1'b1;
    b4.in_val = '0; b4.in_msg = '0; b4.out_rdy = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive sources from the queues at negedge, sample, take the
  // edge, pop whatever was handshaken, then settle 1 time unit past the edge.
  task automatic cyc(input bit use4, input logic ordy);
    @(negedge clk);
    if (use4) begin
      for (int i = 0; i < 4; i++) begin
        b4.in_val[i]       = (q[i].size() != 0);
        b4.in_msg[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
      end
      b4.out_rdy = ordy;
    end else begin
      for (int i = 0; i < 2; i++) begin
        b2.in_val[i]       = (q[i].size() != 0);
        b2.in_msg[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
      end
      b2.out_rdy = ordy;
    end
    #1;
    if (use4) begin
      rdy_s = b4.in_rdy; oval_s = b4.out_val; omsg_s = b4.out_msg; oidx_s = b4.out_idx;
    end else begin
      rdy_s = {2'b00, b2.in_rdy}; oval_s = b2.out_val; omsg_s = b2.out_msg;
      oidx_s = {1'b0, b2.out_idx};
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rdy_s[i] && q[i].size() != 0) void'(q[i].pop_front());
    end
    #1;
  endtask

  logic [7:0] exp3_msg [6];
  logic       exp3_idx [6];
  int cnt [4];
  int got_total;
  int cycles;
  logic ordy;
  logic [7:0] exp_m;

  initial begin
    exp3_msg = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    exp3_idx = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // 1. Reset with every requester valid
    clear_inputs();
    b2.in_val = 2'b11;
    b4.in_val = 4'b1111;
    #12;
    check("rst_in_rdy2", {30'd0, b2.in_rdy}, 32'h0);
    check("rst_out_val2", {31'd0, b2.out_val}, 32'h0);
    check("rst_out_msg2", {24'd0, b2.out_msg}, 32'h0);
    check("rst_in_rdy4", {28'd0, b4.in_rdy}, 32'h0);
    check("rst_out_idx4", {30'd0, b4.out_idx}, 32'h0);
    do_reset();

    // 2. Single requester, src1 idle
    q[0] = '{8'haa, 8'hbb, 8'hcc};
    cyc(1'b0, 1'b1);
    check("single_rdy0", {28'd0, rdy_s}, 32'h1);
    check("single_msg0", {24'd0, b2.out_msg}, 32'haa);
    check("single_idx0", {31'd0, b2.out_idx}, 32'h0);
    cyc(1'b0, 1'b1);
    check("single_val1", {31'd0, b2.out_val}, 32'h1);
    check("single_msg1", {24'd0, b2.out_msg}, 32'hbb);
    cyc(1'b0, 1'b1);
    check("single_msg2", {24'd0, b2.out_msg}, 32'hcc);
    check("single_idx2", {31'd0, b2.out_idx}, 32'h0);
    cyc(1'b0, 1'b1);
    check("single_drain", {31'd0, b2.out_val}, 32'h0);

    // 3. Fairness: both sources continuously valid from ptr=0
    do_reset();
    q[0] = '{8'h11, 8'h12, 8'h13};
    q[1] = '{8'h21, 8'h22, 8'h23};
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1);
      check($sformatf("fair_val%0d", k), {31'd0, b2.out_val}, 32'h1);
      check($sformatf("fair_msg%0d", k), {24'd0, b2.out_msg}, {24'd0, exp3_msg[k]});
      check($sformatf("fair_idx%0d", k), {31'd0, b2.out_idx}, {31'd0, exp3_idx[k]});
    end
    cyc(1'b0, 1'b1);
    check("fair_drain", {31'd0, b2.out_val}, 32'h0);

    // Async reset mid-cycle while full
    q[0] = '{8'h55};
    cyc(1'b0, 1'b0);
    check("async_full", {31'd0, b2.out_val}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_val", {31'd0, b2.out_val}, 32'h0);
    check("async_msg", {24'd0, b2.out_msg}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 4. Backpressure while holding 11
    do_reset();
    q[0] = '{8'h11, 8'h12};
    q[1] = '{8'h21};
    cyc(1'b0, 1'b1);
    check("bp_first", {24'd0, b2.out_msg}, 32'h11);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("bp_rdy%0d", k), {28'd0, rdy_s}, 32'h0);
      check($sformatf("bp_msg%0d", k), {23'd0, b2.out_val, b2.out_msg}, 32'h111);
    end
    cyc(1'b0, 1'b1);
    check("bp_rel_msg", {24'd0, b2.out_msg}, 32'h21);
    check("bp_rel_idx", {31'd0, b2.out_idx}, 32'h1);
    cyc(1'b0, 1'b1);
    check("bp_next_msg", {24'd0, b2.out_msg}, 32'h12);
    cyc(1'b0, 1'b1);
    check("bp_no_dup", {31'd0, b2.out_val}, 32'h0);

    // 5. Wrap and skip on the 4-requester instance
    do_reset();
    q[2] = '{8'h42};
    cyc(1'b1, 1'b1);
    check("wrap_g2_rdy", {28'd0, rdy_s}, 32'h4);
    check("wrap_g2_idx", {30'd0, b4.out_idx}, 32'h2);
    q[1] = '{8'h31};
    cyc(1'b1, 1'b1);
    check("wrap_g1_rdy", {28'd0, rdy_s}, 32'h2);
    check("wrap_g1_out", {22'd0, b4.out_idx, b4.out_msg}, 32'h131);
    q[0] = '{8'h01};
    q[3] = '{8'h73};
    cyc(1'b1, 1'b1);
    check("wrap_g3_rdy", {28'd0, rdy_s}, 32'h8);
    check("wrap_g3_out", {22'd0, b4.out_idx, b4.out_msg}, 32'h373);
    cyc(1'b1, 1'b1);
    check("wrap_g0_rdy", {28'd0, rdy_s}, 32'h1);
    check("wrap_g0_out", {22'd0, b4.out_idx, b4.out_msg}, 32'h001);

    // 6. Integration: 3 sources x 6 msgs, randomly stalled sink
    do_reset();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 6; k++) q[s].push_back(8'(s*16 + k));
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    got_total = 0;
    cycles = 0;
    while (got_total < 18 && cycles < 500) begin
      ordy = ($urandom_range(0, 2) != 0);
      cyc(1'b1, ordy);
      cycles++;
      if (oval_s && ordy) begin
        exp_m = 8'(int'(oidx_s) * 16 + cnt[oidx_s]);
        check($sformatf("integ_src%0d_msg%0d", oidx_s, cnt[oidx_s]),
              {24'd0, omsg_s}, {24'd0, exp_m});
        cnt[oidx_s]++;
        got_total++;
      end
    end
    check("integ_total", got_total, 32'd18);
    check("integ_src0_cnt", cnt[0], 32'd6);
    check("integ_src1_cnt", cnt[1], 32'd6);
    check("integ_src2_cnt", cnt[2], 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
